// File: rtl/sort_floats_pkg.sv
// -----------------------------------------------------------------------------
// sort_floats_pkg
// Shared definitions for the FSM-driven floating-point sorter.
//   FLEN    : element width, taken from the cvw FP configuration (double
//             precision, so one element is a 64-bit IEEE-754 word).
//   state_e : sorter control states with a fixed 2-bit encoding.
// -----------------------------------------------------------------------------
package sort_floats_pkg;

  // Element width used by the surrounding cvw floating-point datapath.
  localparam int FLEN = 64;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SORT = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/sort_floats_n_using_fsm.sv
// -----------------------------------------------------------------------------
// sort_floats_n_using_fsm
// Sorts N floating-point values with an in-place bubble sort. Each SORT cycle
// performs one comparison through a single external f_less_or_equal unit.
// The result appears with a one-cycle valid_out strobe after a fixed latency
// of N*(N-1)/2 + 1 cycles from acceptance.
//
// Ports
//   clk, rst           : clock, synchronous active-high reset
//   valid_in, desc     : request strobe and order select (1 = descending)
//   unsorted           : N operands, sampled when a request is accepted
//   valid_out          : one-cycle result strobe
//   sorted             : result, held until the next accepted request
//   err                : comparator reported an error during this request
//   busy               : high from the cycle after acceptance to valid_out
//   f_le_a, f_le_b     : operands driven to the external comparator
//   f_le_res, f_le_err : same-cycle comparator result (a <= b) and error
// -----------------------------------------------------------------------------
module sort_floats_n_using_fsm
  import sort_floats_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid_in,
  input  logic                   desc,
  input  logic [0:N-1][FLEN-1:0] unsorted,
  output logic                   valid_out,
  output logic [0:N-1][FLEN-1:0] sorted,
  output logic                   err,
  output logic                   busy,
  output logic [FLEN-1:0]        f_le_a,
  output logic [FLEN-1:0]        f_le_b,
  input  logic                   f_le_res,
  input  logic                   f_le_err
);

  localparam int            CW   = $clog2(N);
  // Highest value either counter ever takes.
  localparam logic [CW-1:0] LAST = CW'(N - 2);

  state_e                 state_q, state_d;
  logic [CW-1:0]          p_q, i_q;
  logic [CW-1:0]          i_nxt;
  logic                   pass_end;
  logic                   desc_q, err_q, valid_out_q, busy_q;
  logic [0:N-1][FLEN-1:0] sorted_q;

  assign valid_out = valid_out_q;
  assign sorted    = sorted_q;
  assign err       = err_q;
  assign busy      = busy_q;

  // Next-state decode and comparator operand selection.
  always_comb begin
    state_d  = state_q;
    f_le_a   = '0;
    f_le_b   = '0;
    i_nxt    = i_q + CW'(1);
    // Current pair is the last one of this pass (pass p stops at N-2-p).
    pass_end = (i_q == (LAST - p_q));
    case (state_q)
      IDLE: begin
        if (valid_in) state_d = SORT;
        else          state_d = IDLE;
      end
      SORT: begin
        // Descending order is obtained by swapping the comparator operands,
        // so "in order" always means f_le_res = 1 and equal values stay put.
        if (desc_q) begin
          f_le_a = sorted_q[i_nxt];
          f_le_b = sorted_q[i_q];
        end else begin
          f_le_a = sorted_q[i_q];
          f_le_b = sorted_q[i_nxt];
        end
        if (pass_end && (p_q == LAST)) state_d = DONE;
        else                           state_d = SORT;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, counters, result array and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      p_q         <= '0;
      i_q         <= '0;
      desc_q      <= 1'b0;
      err_q       <= 1'b0;
      valid_out_q <= 1'b0;
      busy_q      <= 1'b0;
      sorted_q    <= '0;
    end else begin
      state_q     <= state_d;
      valid_out_q <= (state_d == DONE);
      busy_q      <= (state_d != IDLE);
      case (state_q)
        IDLE: begin
          if (valid_in) begin
            sorted_q <= unsorted;
            desc_q   <= desc;
            err_q    <= 1'b0;
            p_q      <= '0;
            i_q      <= '0;
          end
        end
        SORT: begin
          // A comparator error leaves the pair untouched and marks the request.
          if (f_le_err) begin
            err_q <= 1'b1;
          end else if (!f_le_res) begin
            sorted_q[i_q]   <= sorted_q[i_nxt];
            sorted_q[i_nxt] <= sorted_q[i_q];
          end
          if (pass_end) begin
            i_q <= '0;
            // On the final comparison p stays at N-2 rather than wrapping.
            if (p_q != LAST) p_q <= p_q + CW'(1);
          end else begin
            i_q <= i_nxt;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
